// File: rtl/ulss_pck_store.sv
// Per-stream packet store: buffers whole packets from ingress and replays one
// complete packet to the rate-limiter scheduler per grant. Bad packets are dropped whole.
module ulss_pck_store #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64,
  parameter int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              rate_limiter_16to4_clk,
  input  logic              rate_limiter_16to4_sw_rst,
  input  logic              wr_valid,
  input  logic              wr_sop,
  input  logic              wr_eop,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pck_rd_en_grnt,
  output logic              pck_str_empty,
  output logic              in_sop,
  output logic [DATA_W-1:0] in_stream,
  output logic              in_eop,
  output logic [15:0]       pck_drop_cnt
);

  localparam int AW = PTR_W - 1;
  localparam int WW = DATA_W + 2;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  typedef enum logic {W_IDLE, W_PKT} w_state_e;
  typedef enum logic {R_IDLE, R_STREAM} r_state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic clk, rst;
  assign clk = rate_limiter_16to4_clk;
  assign rst = rate_limiter_16to4_sw_rst;

  logic [WW-1:0] mem_q [DEPTH];

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  cmt_ptr_q, cmt_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              err_q, err_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic              commit;
  logic [1:0]        drop_inc;

  // A sop inside a packet aborts it; the new packet restarts from the committed pointer.
  logic             wr_abort, wr_take, wr_full, wr_bad;
  logic [PTR_W-1:0] wr_base;
  assign wr_abort = (w_state_q == W_PKT) && wr_valid && wr_sop;
  assign wr_take  = wr_valid && (wr_sop || (w_state_q == W_PKT));
  assign wr_base  = wr_abort ? cmt_ptr_q : wr_ptr_q;
  assign wr_full  = (wr_base - rd_ptr_q) == DEPTH_P;
  assign wr_bad   = (err_q && !wr_sop) || wr_full;

  logic          rd_accept, rd_load;
  logic [WW-1:0] rd_word;
  assign rd_accept = (r_state_q == R_IDLE) && pck_rd_en_grnt && (pkt_cnt_q != '0);
  assign rd_load   = rd_accept || (r_state_q == R_STREAM);
  assign rd_word   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= {wr_sop, wr_eop, wr_data};
  end

  always_comb begin
    w_state_d = w_state_q;
    if (wr_take) w_state_d = wr_eop ? W_IDLE : W_PKT;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = wr_base[AW-1:0];
    commit    = 1'b0;
    drop_inc  = {1'b0, wr_abort};
    if (wr_take) begin
      mem_we   = !wr_bad;
      wr_ptr_d = wr_bad ? wr_base : wr_base + PTR_W'(1);
      err_d    = wr_bad;
      if (wr_eop) begin
        err_d = 1'b0;
        if (wr_bad) begin
          wr_ptr_d = cmt_ptr_q;
          drop_inc = drop_inc + 2'd1;
        end else begin
          cmt_ptr_d = wr_base + PTR_W'(1);
          commit    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    drop_cnt_d = sat_add16(drop_cnt_q, drop_inc);
    pkt_cnt_d  = pkt_cnt_q;
    case ({commit, rd_accept})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // The accepting cycle already loads word 0, so sop follows the grant by one cycle.
  always_comb begin
    r_state_d = r_state_q;
    if (rd_load) r_state_d = rd_word[WW-2] ? R_IDLE : R_STREAM;
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd_load);
    out_sop_d  = 1'b0;
    out_eop_d  = 1'b0;
    out_data_d = '0;
    if (rd_load) begin
      out_sop_d  = rd_word[WW-1];
      out_eop_d  = rd_word[WW-2];
      out_data_d = rd_word[DATA_W-1:0];
    end
  end

  assign pck_str_empty = (pkt_cnt_q == '0);
  assign in_sop        = out_sop_q;
  assign in_eop        = out_eop_q;
  assign in_stream     = out_data_q;
  assign pck_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ulss_pck_store.sv
// Scoreboard bench for ulss_pck_store: a DEPTH=64 and a DEPTH=8 instance share
// stimulus, gated by sel; expected replay words are tagged with their output cycle.
module tb_ulss_pck_store;
  localparam int DW = 64;

  typedef struct {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sel = 1'b0;
  logic          wr_valid = 1'b0, wr_sop = 1'b0, wr_eop = 1'b0, grant = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          va, vb, ga, gb;
  assign va = wr_valid & ~sel;
  assign vb = wr_valid & sel;
  assign ga = grant & ~sel;
  assign gb = grant & sel;

  logic          e_a, sop_a, eop_a, e_b, sop_b, eop_b;
  logic [DW-1:0] data_a, data_b;
  logic [15:0]   drop_a, drop_b;

  ulss_pck_store #(.DATA_W(DW), .DEPTH(64)) dut_a (
    .rate_limiter_16to4_clk(clk), .rate_limiter_16to4_sw_rst(rst),
    .wr_valid(va), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_data(wr_data),
    .pck_rd_en_grnt(ga), .pck_str_empty(e_a), .in_sop(sop_a),
    .in_stream(data_a), .in_eop(eop_a), .pck_drop_cnt(drop_a));

  ulss_pck_store #(.DATA_W(DW), .DEPTH(8)) dut_b (
    .rate_limiter_16to4_clk(clk), .rate_limiter_16to4_sw_rst(rst),
    .wr_valid(vb), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_data(wr_data),
    .pck_rd_en_grnt(gb), .pck_str_empty(e_b), .in_sop(sop_b),
    .in_stream(data_b), .in_eop(eop_b), .pck_drop_cnt(drop_b));

  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  exp_t sb[$];
  exp_t mdl[$];
  bit   mon_en = 1'b0;
  logic [DW+1:0] mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_act = sel ? {sop_b, eop_b, data_b} : {sop_a, eop_a, data_a};
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        check("out_word", mon_act, {sb[0].sop, sb[0].eop, sb[0].data});
        void'(sb.pop_front());
      end else begin
        check("out_idle", mon_act, '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic s, input logic e, input logic [DW-1:0] d, input bit keep);
    exp_t w;
    wr_valid = 1'b1; wr_sop = s; wr_eop = e; wr_data = d;
    if (keep) begin
      w.sop = s; w.eop = e; w.data = d; w.cyc = 0;
      mdl.push_back(w);
    end
    tick();
    wr_valid = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_data = '0;
  endtask

  task automatic wr_pkt(input logic [DW-1:0] base, input int len, input bit keep);
    for (int i = 0; i < len; i++) wr(i == 0, i == len - 1, base + DW'(i), keep);
  endtask

  task automatic gnt(input bit acc);
    exp_t w;
    int   k;
    grant = 1'b1;
    if (acc) begin
      k = 1;
      while (mdl.size() > 0) begin
        w = mdl.pop_front();
        w.cyc = cyc + k;
        sb.push_back(w);
        k++;
        if (w.eop) break;
      end
    end
    tick();
    grant = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_empty_a", e_a, 1);
    check("rst_drop_a", drop_a, 0);
    check("rst_empty_b", e_b, 1);
    check("rst_drop_b", drop_b, 0);
    check("rst_out_b", {sop_b, eop_b, data_b}, 0);
    mon_en = 1'b1;

    // Single 4-word packet
    wr(1, 0, 64'hA0, 1); wr(0, 0, 64'hA1, 1); wr(0, 0, 64'hA2, 1);
    check("t1_empty_pre", e_a, 1);
    wr(0, 1, 64'hA3, 1);
    check("t1_empty_commit", e_a, 0);
    gnt(1);
    check("t1_empty_gnt", e_a, 1);
    repeat (6) tick();

    // Back-to-back replay: grant again in the eop cycle of a 1-word packet
    wr_pkt(64'hB0, 1, 1);
    wr_pkt(64'hC0, 3, 1);
    gnt(1);
    gnt(1);
    repeat (6) tick();
    check("t2_empty", e_a, 1);

    // Stray word (even with eop) is ignored; sop mid-packet aborts the prior one
    wr(0, 1, 64'h55, 0);
    tick();
    check("t3_stray_empty", e_a, 1);
    check("t3_stray_drop", drop_a, 0);
    wr(1, 0, 64'hD0, 0); wr(0, 0, 64'hD1, 0);
    wr_pkt(64'hE0, 3, 1);
    check("t3_abort_drop", drop_a, 1);
    check("t3_abort_empty", e_a, 0);
    gnt(1);
    repeat (6) tick();

    // Grant while empty, then grant mid-replay with another packet waiting
    gnt(0);
    repeat (3) tick();
    wr_pkt(64'hF0, 4, 1);
    wr_pkt(64'h60, 2, 1);
    gnt(1);
    tick();
    gnt(0);
    repeat (5) tick();
    check("t4_one_left", e_a, 0);
    gnt(1);
    repeat (5) tick();
    check("t4_empty", e_a, 1);

    // Reset during word 2 of a replay
    wr_pkt(64'h70, 5, 1);
    gnt(1);
    tick();
    tick();
    rst = 1'b1;
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    mdl.delete();
    tick();
    rst = 1'b0;
    check("t5_rst_empty", e_a, 1);
    check("t5_rst_drop", drop_a, 0);
    wr_pkt(64'h80, 3, 1);
    gnt(1);
    repeat (5) tick();

    // Overflow on the DEPTH=8 instance, then a packet that wraps the pointers
    sel = 1'b1;
    wr_pkt(64'h90, 6, 1);
    wr_pkt(64'hC8, 5, 0);
    check("t6_ovf_drop", drop_b, 1);
    check("t6_ovf_empty", e_b, 0);
    gnt(1);
    repeat (8) tick();
    check("t6_one_pkt", e_b, 1);
    wr_pkt(64'hE8, 3, 1);
    gnt(1);
    repeat (5) tick();
    check("t6_drop_final", drop_b, 1);

    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
